// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared types for the multi-cycle execute-stage ALU.
// Holds the Operation code enum, the top-level FSM state enum and a helper
// that tells which operations run on the iterative datapath.
// Optional build macro used across the slice: ALU_MC_FLAGS_EN.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_EQ   = 4'b1000,
    ALU_MUL  = 4'b1001,
    ALU_DIVU = 4'b1010,
    ALU_REMU = 4'b1011,
    ALU_SLT  = 4'b1100,
    ALU_SLTU = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for the operations that iterate once per result bit.
  function automatic logic is_multicycle(input alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bus between the ID/EX stage, the ALU and EX/MEM.
// master = pipeline side driving operands, slave = the ALU.
// With ALU_MC_FLAGS_EN defined the bus also carries the Zero/Negative flags.
interface alu_mc_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    ALUResult;
`ifdef ALU_MC_FLAGS_EN
  logic                     Zero;
  logic                     Negative;
`endif

  modport master (
    output in_valid, SrcA, SrcB, Operation, out_ready,
    input  in_ready, out_valid, ALUResult
`ifdef ALU_MC_FLAGS_EN
    , input Zero, Negative
`endif
  );

  modport slave (
    input  in_valid, SrcA, SrcB, Operation, out_ready,
    output in_ready, out_valid, ALUResult
`ifdef ALU_MC_FLAGS_EN
    , output Zero, Negative
`endif
  );

endinterface

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shared iterative datapath for MUL (shift-add, low half) and
// DIVU/REMU (restoring division). A start pulse loads the operands, then one
// bit is processed per cycle for DATA_WIDTH cycles. done_o is high during the
// last iteration and result_o already carries the post-iteration value, so the
// top FSM captures it on that same edge.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  alu_op_e               op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  // acc: running product (MUL) or partial remainder (DIVU/REMU)
  // opa: shifted multiplicand (MUL) or dividend turning into quotient (DIV)
  // opb: multiplier shifted right (MUL) or constant divisor (DIV)
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  alu_op_e               op_q, op_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;

  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH:0]   trial;
  logic                  fits;
  logic [DATA_WIDTH-1:0] step_acc;
  logic [DATA_WIDTH-1:0] step_opa;
  logic [DATA_WIDTH-1:0] step_opb;

  // One iteration step; a zero divisor naturally yields all-ones quotient and
  // the dividend as remainder, so no special case is needed.
  always_comb begin
    rem_shift = {acc_q, opa_q[DATA_WIDTH-1]};
    trial     = rem_shift - {1'b0, opb_q};
    fits      = ~trial[DATA_WIDTH];
    if (op_q == ALU_MUL) begin
      step_acc = acc_q + (opb_q[0] ? opa_q : '0);
      step_opa = opa_q << 1;
      step_opb = opb_q >> 1;
    end else begin
      step_acc = fits ? trial[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
      step_opa = {opa_q[DATA_WIDTH-2:0], fits};
      step_opb = opb_q;
    end
  end

  // Load on start, otherwise step and count down while busy.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    acc_d  = acc_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CNT_LAST;
      op_d   = op_i;
      acc_d  = '0;
      opa_d  = a_i;
      opb_d  = b_i;
    end else if (busy_q) begin
      acc_d = step_acc;
      opa_d = step_opa;
      opb_d = step_opb;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= ALU_MUL;
      acc_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      acc_q  <= acc_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
    end
  end

  assign done_o   = busy_q && (cnt_q == '0);
  assign result_o = (op_q == ALU_DIVU) ? step_opa : step_acc;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked execute-stage ALU. Single-cycle ops are evaluated
// combinationally at accept and registered; MUL/DIVU/REMU run on alu_mc_iter.
// in_ready/out_valid let the pipeline stall around multi-cycle operations.
// Optional macro ALU_MC_FLAGS_EN adds registered Zero/Negative flags.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  load_result;
  logic                  accept;
  logic                  op_known;
  alu_op_e               op_code;
  logic                  op_multi;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] single_res;
  logic                  iter_start;
  logic                  iter_done;
  logic [DATA_WIDTH-1:0] iter_result;

  // Opcodes wider than the defined 4-bit space are "other" codes when any
  // upper bit is set.
  if (OPCODE_LENGTH > 4) begin : g_wide_op
    assign op_known = (bus.Operation[OPCODE_LENGTH-1:4] == '0);
  end else begin : g_narrow_op
    assign op_known = 1'b1;
  end

  assign op_code  = alu_op_e'(bus.Operation[3:0]);
  assign op_multi = op_known && is_multicycle(op_code);
  assign shamt    = bus.SrcB[SHAMT_W-1:0];

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.ALUResult = result_q;

  // Single-cycle result evaluated from the live operands at accept time.
  always_comb begin
    single_res = '0;
    case (op_code)
      ALU_AND:  single_res = bus.SrcA & bus.SrcB;
      ALU_OR:   single_res = bus.SrcA | bus.SrcB;
      ALU_ADD:  single_res = bus.SrcA + bus.SrcB;
      ALU_XOR:  single_res = bus.SrcA ^ bus.SrcB;
      ALU_SLL:  single_res = bus.SrcA << shamt;
      ALU_SRL:  single_res = bus.SrcA >> shamt;
      ALU_SUB:  single_res = bus.SrcA - bus.SrcB;
      ALU_SRA:  single_res = $signed(bus.SrcA) >>> shamt;
      ALU_EQ:   single_res = {{(DATA_WIDTH-1){1'b0}}, bus.SrcA == bus.SrcB};
      ALU_SLT:  single_res = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
      ALU_SLTU: single_res = {{(DATA_WIDTH-1){1'b0}}, bus.SrcA < bus.SrcB};
      default:  single_res = '0;
    endcase
    if (!op_known) begin
      single_res = '0;
    end
  end

  // Control FSM: a new accept (from IDLE or while DONE drains) overrides the
  // per-state transition, giving back-to-back issue.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    load_result = 1'b0;
    iter_start  = 1'b0;
    case (state_q)
      IDLE: state_d = IDLE;
      BUSY: begin
        if (iter_done) begin
          state_d     = DONE;
          result_d    = iter_result;
          load_result = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (op_multi) begin
        state_d    = BUSY;
        iter_start = 1'b1;
      end else begin
        state_d     = DONE;
        result_d    = single_res;
        load_result = 1'b1;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  alu_mc_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start_i  (iter_start),
    .op_i     (op_code),
    .a_i      (bus.SrcA),
    .b_i      (bus.SrcB),
    .done_o   (iter_done),
    .result_o (iter_result)
  );

`ifdef ALU_MC_FLAGS_EN
  logic zero_q, zero_d;
  logic neg_q, neg_d;

  // Flags are recomputed only when a new result is loaded, so they track it.
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (load_result) begin
      zero_d = (result_d == '0);
      neg_d  = result_d[DATA_WIDTH-1];
    end
  end

  // Flag registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign bus.Zero     = zero_q;
  assign bus.Negative = neg_q;
`endif

endmodule
